pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, program counter width in bits (legal 2..16).
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries (legal 1..16).
REQ-003 Parameter RESET_ADDR, default 0, PC value loaded at reset (ADDR_W bits).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 stall  input  1  hold all state this cycle; highest priority.
REQ-007 ret  input  1  pop return address into PC.
REQ-008 call  input  1  push PC+1, load target into PC.
REQ-009 jump  input  1  load target into PC.
REQ-010 target  input  ADDR_W  absolute address for call/jump.
REQ-011 branch  input  1  conditional relative branch request.
REQ-012 taken  input  1  branch condition result; qualifies branch.
REQ-013 offset  input  ADDR_W  two's-complement relative branch offset.
REQ-014 pc_out  output  ADDR_W  current program counter, registered.
REQ-015 depth  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-016 stack_full  output  1  depth == STACK_DEPTH, combinational from depth.
REQ-017 stack_empty  output  1  depth == 0, combinational from depth.
REQ-018 ovf_err  output  1  sticky: call attempted while full.
REQ-019 unf_err  output  1  sticky: ret attempted while empty.

Function
REQ-020 Exactly one action per cycle, priority: stall > ret > call > jump > (branch & taken) > increment.
REQ-021 Stall: pc_out, stack contents, depth and error flags unchanged.
REQ-022 Increment (default, incl. branch with taken=0): pc_out <= pc_out+1, modulo 2^ADDR_W (wraps all-ones to 0).
REQ-023 Taken branch: pc_out <= pc_out+offset, ADDR_W-bit modulo sum, offset sign-interpreted, carry discarded.
REQ-024 Jump: pc_out <= target; stack untouched.
REQ-025 Call, not full: stack[depth] <= pc_out+1 (wrapped), depth <= depth+1, pc_out <= target.
REQ-026 Call while full: no push, depth unchanged, pc_out <= pc_out+1, ovf_err <= 1.
REQ-027 Ret, not empty: pc_out <= stack[depth-1], depth <= depth-1.
REQ-028 Ret while empty: pc_out <= pc_out+1, unf_err <= 1.
REQ-029 ret and call asserted together: ret executes, call ignored (no push).
REQ-030 All outputs update one cycle after the qualifying edge; single-cycle latency, no bubbles.
REQ-031 Stack is LIFO; entries above depth are don't-care and never observable.
REQ-032 Error flags clear only on reset.

Reset
REQ-033 When reset==0 at a rising edge: pc_out <= RESET_ADDR, depth <= 0, ovf_err <= 0, unf_err <= 0; stack_empty=1, stack_full=0 follow.
REQ-034 Reset overrides stall and all other inputs, including mid call/ret sequences; stack contents need not be cleared.
REQ-035 No state changes asynchronously to clk.

Verification
REQ-036 Defaults, reset low 2 cycles then high, no requests, 18 cycles -> pc_out 0,1,...,F,0,1 (wrap at 4 bits).
REQ-037 pc_out=3, branch=1 taken=1 offset=4'hE -> pc_out=1; same with taken=0 -> pc_out=4.
REQ-038 pc_out=2, call target=8 -> pc_out=8, depth=1; next cycle ret -> pc_out=3, depth=0, stack_empty=1.
REQ-039 Five nested calls (depth 4) -> 5th call: pc_out increments, depth stays 4, stack_full=1, ovf_err=1; four rets return addresses in reverse order.
REQ-040 ret with depth=0 at pc_out=7 -> pc_out=8, unf_err=1 held until reset; stall=1 with call=1 -> no change in any output.
REQ-041 depth=2, assert reset low with call=1 -> next cycle pc_out=RESET_ADDR, depth=0, both error flags 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return-address stack
//
// Purpose:
//   Holds the program counter and a small LIFO of return addresses.
//   Each cycle performs exactly one action, chosen in this priority order:
//   stall, ret, call, jump, taken branch, increment.
//   Misuse of the stack is recorded in sticky error flags.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   stall        hold all state this cycle
//   ret          pop a return address into the PC
//   call         push PC+1 and load target into the PC
//   jump         load target into the PC
//   target       absolute address for call/jump
//   branch       relative branch request
//   taken        branch condition result; qualifies branch
//   offset       two's-complement branch offset
//   pc_out       current program counter (registered)
//   depth        number of valid stack entries (registered)
//   stack_full   depth == STACK_DEPTH
//   stack_empty  depth == 0
//   ovf_err      sticky: call attempted while the stack was full
//   unf_err      sticky: ret attempted while the stack was empty

module pc_sequencer #(
  parameter int                ADDR_W      = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               ret,
  input  logic                               call,
  input  logic                               jump,
  input  logic [ADDR_W-1:0]                  target,
  input  logic                               branch,
  input  logic                               taken,
  input  logic [ADDR_W-1:0]                  offset,
  output logic [ADDR_W-1:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               ovf_err,
  output logic                               unf_err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  // Index width into the stack array; a one-entry stack still needs one bit.
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_branch;
  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     pop_idx;

  assign stack_full  = (depth == DW'(STACK_DEPTH));
  assign stack_empty = (depth == '0);

  // Both sums are ADDR_W wide, so the carry out is dropped and the
  // offset behaves as a signed value under modular arithmetic.
  assign pc_inc    = pc_out + ADDR_W'(1);
  assign pc_branch = pc_out + offset;

  // A push only happens when depth < STACK_DEPTH and a pop only when
  // depth > 0, so truncating to the array index width is always in range.
  assign push_idx = IW'(depth);
  assign pop_idx  = IW'(depth - DW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out  <= RESET_ADDR;
      depth   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (!stall) begin
      if (ret) begin
        // ret outranks call, so a simultaneous call is dropped entirely.
        if (stack_empty) begin
          pc_out  <= pc_inc;
          unf_err <= 1'b1;
        end else begin
          pc_out <= stack[pop_idx];
          depth  <= depth - DW'(1);
        end
      end else if (call) begin
        if (stack_full) begin
          pc_out  <= pc_inc;
          ovf_err <= 1'b1;
        end else begin
          stack[push_idx] <= pc_inc;
          depth           <= depth + DW'(1);
          pc_out          <= target;
        end
      end else if (jump) begin
        pc_out <= target;
      end else if (branch && taken) begin
        pc_out <= pc_branch;
      end else begin
        pc_out <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
//
// Purpose:
//   Drives pc_sequencer with a free-running count, a table of vectors
//   covering branches, nested calls, stack overflow/underflow, stall and
//   reset, and a randomized phase checked against a queue-based model.
//
// Ports: none (top-level bench)

module tb_pc_sequencer;

  localparam int W   = 4;
  localparam int D   = 4;
  localparam int DW  = $clog2(D + 1);
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          reset, stall, ret, call, jump, branch, taken;
  logic [W-1:0]  target, offset;
  logic [W-1:0]  pc_out;
  logic [DW-1:0] depth;
  logic          stack_full, stack_empty, ovf_err, unf_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W      (W),
    .STACK_DEPTH (D),
    .RESET_ADDR  ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .ret         (ret),
    .call        (call),
    .jump        (jump),
    .target      (target),
    .branch      (branch),
    .taken       (taken),
    .offset      (offset),
    .pc_out      (pc_out),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  // Reference model: a plain integer PC and a queue used as the stack.
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  function automatic int wrap(int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  function automatic int signed_off(logic [W-1:0] o);
    int v;
    v = int'(o);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_stk.size() == 0) begin
        m_unf = 1;
        m_pc  = wrap(m_pc + 1);
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (call) begin
      if (m_stk.size() == D) begin
        m_ovf = 1;
        m_pc  = wrap(m_pc + 1);
      end else begin
        m_stk.push_back(wrap(m_pc + 1));
        m_pc = int'(target);
      end
    end else if (jump) begin
      m_pc = int'(target);
    end else if (branch && taken) begin
      m_pc = wrap(m_pc + signed_off(offset));
    end else begin
      m_pc = wrap(m_pc + 1);
    end
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(string tag, int e_pc, int e_dep, bit e_ovf, bit e_unf);
    check({tag, " pc_out"},      16'(pc_out),      16'(e_pc));
    check({tag, " depth"},       16'(depth),       16'(e_dep));
    check({tag, " stack_full"},  16'(stack_full),  16'(e_dep == D));
    check({tag, " stack_empty"}, 16'(stack_empty), 16'(e_dep == 0));
    check({tag, " ovf_err"},     16'(ovf_err),     16'(e_ovf));
    check({tag, " unf_err"},     16'(unf_err),     16'(e_unf));
  endtask

  task automatic idle_inputs();
    reset  = 1'b1;
    stall  = 1'b0;
    ret    = 1'b0;
    call   = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    taken  = 1'b0;
    target = '0;
    offset = '0;
  endtask

  // Inputs change 1 time unit after the rising edge and outputs are
  // sampled at the same point, well clear of the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         rst_n;
    bit         stall;
    bit         ret;
    bit         call;
    bit         jump;
    bit         branch;
    bit         taken;
    logic [3:0] target;
    logic [3:0] offset;
    int         e_pc;
    int         e_dep;
    bit         e_ovf;
    bit         e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rn, bit st, bit rt, bit cl, bit jp, bit br, bit tk,
                              logic [3:0] tg, logic [3:0] of,
                              int pc, int dp, bit ov, bit un);
    vec_t v;
    v.rst_n = rn; v.stall = st; v.ret = rt; v.call = cl; v.jump = jp;
    v.branch = br; v.taken = tk; v.target = tg; v.offset = of;
    v.e_pc = pc; v.e_dep = dp; v.e_ovf = ov; v.e_unf = un;
    return v;
  endfunction

  initial begin
    idle_inputs();

    // Rows run back to back from a freshly reset state (pc=0, depth=0).
    //              rn st rt cl jp br tk tgt    off     pc  dp ov un
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'h3, 4'h0, 'h3, 0, 0, 0)); // jump 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4'h0, 4'hE, 'h1, 0, 0, 0)); // 3 + (-2)
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'h3, 4'h0, 'h3, 0, 0, 0)); // jump 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'h0, 4'hE, 'h4, 0, 0, 0)); // not taken
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'h2, 4'h0, 'h2, 0, 0, 0)); // jump 2
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'h8, 4'h0, 'h8, 1, 0, 0)); // call 8
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 'h3, 0, 0, 0)); // ret -> 3
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'hA, 4'h0, 'hA, 1, 0, 0)); // push 4
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'h5, 4'h0, 'h5, 2, 0, 0)); // push B
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'hC, 4'h0, 'hC, 3, 0, 0)); // push 6
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'h1, 4'h0, 'h1, 4, 0, 0)); // push D, full
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'h9, 4'h0, 'h2, 4, 1, 0)); // overflow
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 'hD, 3, 1, 0)); // ret D
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 'h6, 2, 1, 0)); // ret 6
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 4'hF, 4'h0, 'hB, 1, 1, 0)); // ret wins over call
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 'h4, 0, 1, 0)); // ret 4
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'h7, 4'h0, 'h7, 0, 1, 0)); // jump 7
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 'h8, 0, 1, 1)); // underflow
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 'h8, 0, 1, 1)); // stall + call
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 'h8, 0, 1, 1)); // stall + ret
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 'h9, 0, 1, 1)); // increment
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 'h0, 1, 1, 1)); // call 0
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 'h0, 2, 1, 1)); // call 0
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 4'h5, 4'h0, 'h0, 0, 0, 0)); // reset beats all
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 'h1, 0, 0, 0)); // increment
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 4'h6, 4'h1, 'h6, 0, 0, 0)); // jump over branch
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4'h0, 4'hF, 'h5, 0, 0, 0)); // 6 + (-1)
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4'h0, 4'hD, 'h2, 0, 0, 0)); // 5 + (-3)
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4'h0, 4'h7, 'h9, 0, 0, 0)); // 2 + 7

    // Reset low for two cycles, then a free-running count that wraps.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_state("reset", 0, 0, 0, 0);
    for (int i = 1; i < 18; i++) begin
      tick();
      check({"count ", $sformatf("%0d", i)}, 16'(pc_out), 16'(i % MOD));
    end

    // Table-driven vectors from a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_state("table start", 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst_n;
      stall  = vecs[i].stall;
      ret    = vecs[i].ret;
      call   = vecs[i].call;
      jump   = vecs[i].jump;
      branch = vecs[i].branch;
      taken  = vecs[i].taken;
      target = vecs[i].target;
      offset = vecs[i].offset;
      tick();
      check_state($sformatf("vec %0d", i), vecs[i].e_pc, vecs[i].e_dep,
                  vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Error flags stay set through many idle cycles until reset.
    idle_inputs();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("unf sticky", 16'(unf_err), 16'(1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("unf cleared", 16'(unf_err), 16'(0));

    // Randomized phase against the queue model, synced by a reset cycle.
    idle_inputs();
    reset = 1'b0;
    tick();
    model_step();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 99) != 0);
      stall  = ($urandom_range(0, 7) == 0);
      ret    = ($urandom_range(0, 5) == 0);
      call   = ($urandom_range(0, 4) == 0);
      jump   = ($urandom_range(0, 7) == 0);
      branch = ($urandom_range(0, 3) == 0);
      taken  = $urandom_range(0, 1) == 1;
      target = W'($urandom_range(0, MOD - 1));
      offset = W'($urandom_range(0, MOD - 1));
      tick();
      model_step();
      check_state($sformatf("rand %0d", i), m_pc, m_stk.size(), m_ovf, m_unf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
